uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Memory-mapped UART transmitter with a byte FIFO, downstream of the CPU data-memory bus inside soc; drives the soc uart_tx pin.
- CPU stores bytes to a DATA register; the block serialises them as 8N1 (LSB first) at a fixed clocks-per-bit rate.
- STATUS register exposes FIFO/transmitter state and a sticky overflow flag so firmware can poll before writing.

Parameters:
- clks_per_bit, 868, clock cycles per UART bit (>=2)
- fifo_depth, 8, FIFO entries (power of two, >=2)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- mem_valid  input  1  bus request valid
- mem_addr  input  32  byte address; only bit [2] decoded (0x0 DATA, 0x4 STATUS)
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte strobes; nonzero = write, zero = read
- mem_rdata  output  32  read data, valid while mem_ready=1
- mem_ready  output  1  one-cycle completion pulse
- uart_tx  output  1  serial output, idle high

Behaviour:
- Reset (reset=0, async): uart_tx=1, mem_ready=0, mem_rdata=0, FIFO empty (count=0, pointers 0), overflow=0, FSM=IDLE, bit counters 0.
- Bus handshake: request accepted on a rising edge with mem_valid=1 and mem_ready=0; mem_ready=1 for exactly the following cycle, then 0. Master drops mem_valid after seeing mem_ready. A held mem_valid therefore produces one access per two cycles; never a double push.
- DATA write (addr[2]=0, wstrb[0]=1): push wdata[7:0] if FIFO not full. Fullness is evaluated on the pre-edge count; a same-cycle pop does not make room. If full: byte dropped, overflow<=1. Writes with wstrb[0]=0 are ignored.
- DATA read: rdata=0.
- STATUS read (addr[2]=1): bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 overflow, bits[15:8] count (zero-extended), others 0. Values sampled at the accepting edge.
- STATUS write with wstrb[0]=1 and wdata[3]=1: clear overflow. An overflow set in the same cycle wins.
- FIFO: circular buffer, pointers wrap modulo fifo_depth, count 0..fifo_depth. Simultaneous push and pop when not full leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP (PARITY when enabled).
  - IDLE: if FIFO non-empty, pop into shift register, goto START, uart_tx<=0.
  - START: hold 0 for clks_per_bit cycles, goto DATA.
  - DATA: shift out bit0 first, each held clks_per_bit cycles; after bit 7 goto STOP (or PARITY).
  - STOP: hold 1 for clks_per_bit cycles, goto IDLE.
- Latency: byte accepted at edge E0; popped at E1; uart_tx low from E1. Frame = 10*clks_per_bit cycles. Back-to-back bytes: STOP->IDLE->START adds one idle-high cycle between frames.
- Bit-time counter counts 0..clks_per_bit-1; the state advances when it reaches the terminal count.
- Reset mid-frame: uart_tx returns to 1 immediately; FIFO contents are lost.

Optional Feature:
- UART_TX_PARITY_EN: when defined, a PARITY state follows DATA and transmits even parity (XOR of the 8 data bits) for clks_per_bit cycles before STOP; frame = 11*clks_per_bit. STATUS bit4 reads 1.
- When undefined: no PARITY state, 8N1 framing, STATUS bit4 reads 0.

Test Plan:
- clks_per_bit=4: write DATA=0x55 -> mem_ready pulse next cycle; uart_tx low from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; busy=1 for 40 cycles.
- fifo_depth=4: write 0x01..0x06 back-to-back (every 2 cycles) -> 0x01 popped to shifter, 0x02..0x05 queued, 0x06 dropped; STATUS reads full=1, overflow=1, count=4; serial output is 0x01..0x05 in order.
- After overflow: write STATUS wdata=0x8, wstrb=0x1 -> subsequent STATUS read shows bit3=0, other fields unchanged.
- Idle STATUS read after reset -> rdata=0x00000002 (empty=1); DATA read -> 0x00000000.
- Assert reset=0 midway through a frame of 0xA3 -> uart_tx=1 immediately; after release STATUS=0x2 and no further frame is transmitted.
- With UART_TX_PARITY_EN, clks_per_bit=4, write 0x07 -> parity bit 1 after the data bits; frame = 44 cycles; STATUS bit4=1.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter fed by a byte FIFO; DATA at 0x0, STATUS at 0x4.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_buffered #(
    parameter int clks_per_bit = 868,
    parameter int fifo_depth   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        uart_tx
);

    localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clks_per_bit - 1);
    localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(fifo_depth);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic [7:0]       fifo_q [fifo_depth];

    logic        accept, is_status, is_write;
    logic        fifo_full, fifo_empty;
    logic        push_req, push, pop, bit_done;
    logic [31:0] status_word;
    logic        unused_bits;

    assign unused_bits = ^{mem_addr[31:3], mem_addr[1:0], mem_wdata[31:8]};

    // Bus decode and FIFO bookkeeping all act on the pre-edge FIFO count.
    always_comb begin
        accept     = mem_valid && !ready_q;
        is_status  = mem_addr[2];
        is_write   = |mem_wstrb;
        fifo_full  = (count_q == DEPTH);
        fifo_empty = (count_q == '0);
        push_req   = accept && !is_status && mem_wstrb[0];
        push       = push_req && !fifo_full;
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        bit_done   = (bit_cnt_q == CNT_LAST);
        status_word = {16'h0, 8'(count_q), 3'b0, PARITY_FLAG, overflow_q,
                       (state_q != ST_IDLE), fifo_empty, fifo_full};

        ready_d    = accept;
        rdata_d    = (accept && !is_write && is_status) ? status_word : 32'h0;
        overflow_d = overflow_q;
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end else if (accept && is_status && mem_wstrb[0] && mem_wdata[3]) begin
            overflow_d = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            bit_cnt_d = bit_done ? '0 : bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    shift_d   = fifo_q[rd_ptr_q];
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^fifo_q[rd_ptr_q];
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            // The shifter keeps the current bit in [0]; shifting exposes the next one.
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h0;
            tx_q       <= 1'b1;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the count and pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign uart_tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a queue/timestamp model predicts bus reads and
// serial frames; independent monitors compare them against what the DUT presents.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   FRAME    = 11 * CPB;
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam int   FRAME    = 10 * CPB;
    localparam logic PAR_FLAG = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        uart_tx;

    uart_tx_buffered #(.clks_per_bit(CPB), .fifo_depth(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .uart_tx  (uart_tx)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } bus_exp_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mq[$];
    logic [7:0]  exp_serial[$];
    bus_exp_t    exp_bus[$];
    int          t = 0;
    int          busy_end = 0;
    bit          ovf_m = 1'b0;
    bit          ready_m = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as "busy until edge busy_end".
    initial begin : model
        int       pre_size;
        bit       busy_m, acc, rd;
        bus_exp_t e;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                exp_serial.delete();
                exp_bus.delete();
                busy_end = 0;
                ovf_m    = 1'b0;
                ready_m  = 1'b0;
            end else begin
                t++;
                pre_size = mq.size();
                busy_m   = (t <= busy_end);
                acc      = mem_valid && !ready_m;
                if (acc) begin
                    rd        = (mem_wstrb == 4'h0);
                    e.is_read = rd;
                    e.data    = 32'h0;
                    if (rd && mem_addr[2])
                        e.data = {16'h0, 8'(pre_size), 3'b0, PAR_FLAG, ovf_m, busy_m,
                                  (pre_size == 0), (pre_size == DEPTH)};
                    exp_bus.push_back(e);
                    if (!mem_addr[2] && mem_wstrb[0]) begin
                        if (pre_size == DEPTH) ovf_m = 1'b1;
                        else mq.push_back(mem_wdata[7:0]);
                    end else if (mem_addr[2] && mem_wstrb[0] && mem_wdata[3]) begin
                        ovf_m = 1'b0;
                    end
                end
                ready_m = acc;
                if (!busy_m && pre_size > 0) begin
                    exp_serial.push_back(mq.pop_front());
                    busy_end = t + FRAME;
                end
            end
        end
    end

    // Bus monitor: handshake timing and read data.
    initial begin : bus_monitor
        bus_exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (mem_ready || ready_m))
                check_output("ready_timing", {31'b0, mem_ready}, {31'b0, ready_m});
            if (reset && mem_ready) begin
                if (exp_bus.size() == 0) begin
                    check_output("unexpected_ready", 32'h1, 32'h0);
                end else begin
                    e = exp_bus.pop_front();
                    if (e.is_read) check_output("rdata", mem_rdata, e.data);
                end
            end
        end
    end

    // Serial monitor: capture a whole frame per cycle and compare with the ideal waveform.
    logic samp [FRAME];
    initial begin : serial_monitor
        bit         aborted;
        logic [7:0] eb, dec;
        int         errs, idx;
        logic       want;
        forever begin
            @(negedge clock);
            if (reset && uart_tx === 1'b0) begin
                aborted = 1'b0;
                samp[0] = uart_tx;
                for (int c = 1; c < FRAME; c++) begin
                    @(negedge clock);
                    if (!reset) aborted = 1'b1;
                    samp[c] = uart_tx;
                end
                if (!aborted) begin
                    if (exp_serial.size() == 0) begin
                        check_output("unexpected_frame", 32'h1, 32'h0);
                    end else begin
                        eb   = exp_serial.pop_front();
                        errs = 0;
                        for (int c = 0; c < FRAME; c++) begin
                            idx = c / CPB;
                            if (idx == 0) want = 1'b0;
                            else if (idx <= 8) want = eb[idx-1];
                            else if (PAR_FLAG && idx == 9) want = ^eb;
                            else want = 1'b1;
                            if (samp[c] !== want) errs++;
                        end
                        for (int i = 0; i < 8; i++) dec[i] = samp[(i + 1) * CPB + CPB / 2];
                        check_output("frame_byte", {24'h0, dec}, {24'h0, eb});
                        check_output("frame_shape_errs", errs, 0);
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb);
        bit ok;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output("ready_timeout", 32'h0, 32'h1);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || t <= busy_end + 1) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) check_output("drain_timeout", 32'h0, 32'h1);
        idle(FRAME + 4);
    endtask

    initial begin : stimulus
        logic [31:0] a, d;
        logic [3:0]  s;
        int          r;
        #1 reset = 1'b0;
        #2;
        check_output("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check_output("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
        check_output("reset_mem_rdata", mem_rdata, 32'h0);
        idle(3);
        reset = 1'b1;
        idle(2);

        apply_stimulus(32'h4, 32'h0, 4'h0);
        apply_stimulus(32'h0, 32'h0, 4'h0);

        apply_stimulus(32'h0, 32'h55, 4'h1);
        for (int i = 0; i < 25; i++) apply_stimulus(32'h4, 32'h0, 4'h0);
        drain();

        for (int i = 1; i <= 6; i++) apply_stimulus(32'h0, i, 4'h1);
        apply_stimulus(32'h4, 32'h0, 4'h0);
        apply_stimulus(32'h4, 32'h8, 4'h1);
        apply_stimulus(32'h4, 32'h0, 4'h0);
        drain();

        apply_stimulus(32'h0, 32'h07, 4'hF);
        apply_stimulus(32'h0, 32'h00, 4'hE);
        apply_stimulus(32'h4, 32'h0, 4'h0);
        drain();

        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
            case (r)
                0, 1, 2, 3, 4: begin a[2] = 1'b0; apply_stimulus(a, d, s); end
                5:             begin a[2] = 1'b0; apply_stimulus(a, d, 4'h0); end
                6, 7:          begin a[2] = 1'b1; apply_stimulus(a, d, 4'h0); end
                8:             begin a[2] = 1'b1; apply_stimulus(a, d, s); end
                default:       idle($urandom_range(5, 60));
            endcase
        end
        drain();

        apply_stimulus(32'h0, 32'hA3, 4'h1);
        idle(12);
        #2 reset = 1'b0;
        #1;
        check_output("midframe_reset_tx", {31'b0, uart_tx}, 32'h1);
        check_output("midframe_reset_ready", {31'b0, mem_ready}, 32'h0);
        idle(3);
        reset = 1'b1;
        idle(1);
        apply_stimulus(32'h4, 32'h0, 4'h0);
        idle(FRAME + 20);

        check_output("serial_left", exp_serial.size(), 0);
        check_output("bus_left", exp_bus.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
